// File: rtl/kyber_pkg.sv
// Shared Kyber coefficient types and constants (q = 7681, 13-bit coefficients).
// Also provides the modular reduction helper used by mult_mod.
package kyber_pkg;
    localparam int WIDTH = 13;
    localparam logic [WIDTH-1:0] Q = 13'd7681;

    typedef logic [WIDTH-1:0] coeff_t;

    typedef struct packed {
        coeff_t hi;
        coeff_t lo;
    } fifo_entry_t;

    function automatic coeff_t mod_q(input logic [2*WIDTH-1:0] x);
        logic [2*WIDTH-1:0] r;
        r = x % {13'd0, Q};
        return r[WIDTH-1:0];
    endfunction
endpackage

// File: rtl/ntt_butterfly_if.sv
// Handshake bundle for ntt_butterfly: input pair/twiddle side and result side.
// The master modport drives operands; the slave modport is the butterfly.
interface ntt_butterfly_if import kyber_pkg::*; ();
    logic   in_valid;
    logic   in_ready;
    logic   mode;
    coeff_t u;
    coeff_t v;
    coeff_t w;
    logic   out_valid;
    logic   out_ready;
    coeff_t out_hi;
    coeff_t out_lo;

    modport master (
        output in_valid, mode, u, v, w, out_ready,
        input  in_ready, out_valid, out_hi, out_lo
    );

    modport slave (
        input  in_valid, mode, u, v, w, out_ready,
        output in_ready, out_valid, out_hi, out_lo
    );
endinterface

// File: rtl/mult_mod.sv
// Free-running modular multiplier: mod_prod = a*b mod q, MULT_LAT cycles after a/b.
// No enable; the caller tracks which pipeline slots carry real items.
module mult_mod import kyber_pkg::*; #(
    parameter int MULT_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t mod_prod
);
    coeff_t pipe_r [MULT_LAT];

    // Reduce the product on entry, then delay it to the configured latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= mod_q({13'd0, a} * {13'd0, b});
            for (int i = 1; i < MULT_LAT; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign mod_prod = pipe_r[MULT_LAT-1];
endmodule

// File: rtl/ntt_butterfly_add_sub.sv
// mod_add_sub: combinational (a+b) mod q and (a-b) mod q for operands already below q.
module mod_add_sub import kyber_pkg::*; (
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t sum,
    output coeff_t diff
);
    logic [WIDTH:0] raw_sum_s;
    logic [WIDTH:0] red_sum_s;

    // Single conditional correction suffices because both operands are < q.
    always_comb begin
        raw_sum_s = {1'b0, a} + {1'b0, b};
        red_sum_s = raw_sum_s - {1'b0, Q};
        if (raw_sum_s >= {1'b0, Q}) begin
            sum = red_sum_s[WIDTH-1:0];
        end else begin
            sum = raw_sum_s[WIDTH-1:0];
        end
        if (a < b) begin
            diff = a + (Q - b);
        end else begin
            diff = a - b;
        end
    end
endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Kyber NTT butterfly wrapping mult_mod, with a credit-guarded output skid FIFO.
// Define NTT_BUTTERFLY_GS_EN to add per-item Gentleman-Sande (inverse) mode.
module ntt_butterfly import kyber_pkg::*; #(
    parameter int MULT_LAT   = 2,
    parameter int FIFO_DEPTH = MULT_LAT + 2
) (
    input logic           clk,
    input logic           rst,
    ntt_butterfly_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + MULT_LAT + 2) + 1;
    typedef logic [CW-1:0] cnt_t;

    logic                accept_s, pop_s;
    logic [MULT_LAT-1:0] vld_sr_r;
    coeff_t              part_r [MULT_LAT];
    coeff_t              mul_b_s, part_in_s, prod_s;
    coeff_t              ct_hi_s, ct_lo_s, fin_hi_s, fin_lo_s;
    logic                fin_valid_r;
    coeff_t              fin_hi_r, fin_lo_r;
    fifo_entry_t         mem_r [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
    cnt_t                count_r, count_next_s, total_s, total_next_s;
    logic                in_ready_r, out_valid_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) return '0;
        else return p + 1'b1;
    endfunction

    assign accept_s = bus.in_valid && in_ready_r;
    assign pop_s    = out_valid_r && bus.out_ready;

`ifdef NTT_BUTTERFLY_GS_EN
    logic [MULT_LAT-1:0] mode_sr_r;
    coeff_t              in_sum_s, in_diff_s;

    mod_add_sub u_in_as (.a(bus.u), .b(bus.v), .sum(in_sum_s), .diff(in_diff_s));

    // GS multiplies the difference and carries the sum; CT multiplies v and carries u.
    always_comb begin
        if (bus.mode) begin
            mul_b_s   = in_diff_s;
            part_in_s = in_sum_s;
        end else begin
            mul_b_s   = bus.v;
            part_in_s = bus.u;
        end
    end

    // Per-item mode travels alongside the multiplier pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sr_r <= '0;
        end else begin
            mode_sr_r[0] <= bus.mode;
            for (int i = 1; i < MULT_LAT; i++) mode_sr_r[i] <= mode_sr_r[i-1];
        end
    end

    // GS results bypass the output add/sub stage.
    always_comb begin
        if (mode_sr_r[MULT_LAT-1]) begin
            fin_hi_s = part_r[MULT_LAT-1];
            fin_lo_s = prod_s;
        end else begin
            fin_hi_s = ct_hi_s;
            fin_lo_s = ct_lo_s;
        end
    end
`else
    assign mul_b_s   = bus.v;
    assign part_in_s = bus.u;
    assign fin_hi_s  = ct_hi_s;
    assign fin_lo_s  = ct_lo_s;
`endif

    mult_mod #(.MULT_LAT(MULT_LAT)) u_mult (
        .clk(clk), .rst(rst), .a(bus.w), .b(mul_b_s), .mod_prod(prod_s)
    );

    mod_add_sub u_out_as (.a(part_r[MULT_LAT-1]), .b(prod_s), .sum(ct_hi_s), .diff(ct_lo_s));

    // Valid tracking and partial delay line aligned with mult_mod, then the registered add/sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_r    <= '0;
            for (int i = 0; i < MULT_LAT; i++) part_r[i] <= '0;
            fin_valid_r <= 1'b0;
            fin_hi_r    <= '0;
            fin_lo_r    <= '0;
        end else begin
            vld_sr_r[0] <= accept_s;
            part_r[0]   <= part_in_s;
            for (int i = 1; i < MULT_LAT; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
                part_r[i]   <= part_r[i-1];
            end
            fin_valid_r <= vld_sr_r[MULT_LAT-1];
            fin_hi_r    <= fin_hi_s;
            fin_lo_r    <= fin_lo_s;
        end
    end

    // Everything buffered or in flight counts against the FIFO's capacity.
    always_comb begin
        total_s = count_r + cnt_t'(fin_valid_r);
        for (int i = 0; i < MULT_LAT; i++) total_s = total_s + cnt_t'(vld_sr_r[i]);
        total_next_s = total_s + cnt_t'(accept_s) - cnt_t'(pop_s);
        count_next_s = count_r + cnt_t'(fin_valid_r) - cnt_t'(pop_s);
    end

    // Skid FIFO; credit flow guarantees a push never meets a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (fin_valid_r) begin
                mem_r[wr_ptr_r] <= '{hi: fin_hi_r, lo: fin_lo_r};
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r     <= count_next_s;
            in_ready_r  <= (total_next_s < cnt_t'(FIFO_DEPTH));
            out_valid_r <= (count_next_s != '0);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_hi    = mem_r[rd_ptr_r].hi;
    assign bus.out_lo    = mem_r[rd_ptr_r].lo;
endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: expectations are queued on acceptance and
// compared in order as results leave the FIFO.
module tb_ntt_butterfly;
    import kyber_pkg::*;

    localparam int L     = 2;
    localparam int DEPTH = L + 2;
    localparam int QI    = 7681;

    typedef struct {
        int hi;
        int lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_recv = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ntt_butterfly_if bif ();

    ntt_butterfly #(.MULT_LAT(L), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int u, input int v, input int w, input logic m);
        exp_t e;
        int   p;
`ifdef NTT_BUTTERFLY_GS_EN
        if (m) begin
            e.hi = (u + v) % QI;
            e.lo = (((u - v + QI) % QI) * w) % QI;
            return e;
        end
`endif
        p    = (w * v) % QI;
        e.hi = (u + p) % QI;
        e.lo = (u - p + QI) % QI;
        return e;
    endfunction

    // Output monitor: every transfer out must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bif.out_valid && bif.out_ready) begin
            n_recv++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_hi", int'(bif.out_hi), mon_e.hi);
                check("out_lo", int'(bif.out_lo), mon_e.lo);
            end
        end
    end

    task automatic send(input int u, input int v, input int w, input logic m,
                        input int eh, input int el);
        int waited = 0;
        bif.in_valid = 1'b1;
        bif.u = coeff_t'(u);
        bif.v = coeff_t'(v);
        bif.w = coeff_t'(w);
        bif.mode = m;
        while (!bif.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bif.in_ready) begin
            check("in_ready_timeout", 0, 1);
            bif.in_valid = 1'b0;
        end else begin
            exp_q.push_back('{eh, el});
            @(posedge clk); #1;
            bif.in_valid = 1'b0;
        end
    endtask

    task automatic send_rand(input logic m);
        int u, v, w;
        exp_t e;
        u = $urandom_range(QI - 1, 0);
        v = $urandom_range(QI - 1, 0);
        w = $urandom_range(QI - 1, 0);
        e = model(u, v, w, m);
        send(u, v, w, m, e.hi, e.lo);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, k, accepted, recv0;
        exp_t e;
        logic m;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.mode = 1'b0;
        bif.u = '0;
        bif.v = '0;
        bif.w = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bif.in_ready), 1);
        check("rst_out_valid", int'(bif.out_valid), 0);
        check("rst_out_hi", int'(bif.out_hi), 0);
        check("rst_out_lo", int'(bif.out_lo), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // First-result latency into an empty FIFO.
        bif.out_ready = 1'b1;
        bif.in_valid = 1'b1;
        bif.u = 13'd100;
        bif.v = 13'd6651;
        bif.w = 13'd4592;
        check("lat_in_ready", int'(bif.in_ready), 1);
        t0 = cyc;
        exp_q.push_back('{1836, 6045});
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        k = 0;
        while (!bif.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("latency", cyc - t0, L + 2);
        drain();

        // Directed vectors, back to back.
        send(7000, 7265, 5623, 1'b0, 2856, 3463);
        send(7680, 1, 1, 1'b0, 0, 7679);
        send(0, 0, 0, 1'b0, 0, 0);
`ifdef NTT_BUTTERFLY_GS_EN
        send(100, 6651, 4592, 1'b1, 6751, 4285);
        send(100, 6651, 4592, 1'b0, 1836, 6045);
`endif
        drain();

        // Random stream with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
`ifdef NTT_BUTTERFLY_GS_EN
                    m = 1'($urandom_range(1, 0));
`else
                    m = 1'b0;
`endif
                    send_rand(m);
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #1;
                    bif.out_ready = 1'($urandom_range(1, 0));
                end
            end
        join
        bif.out_ready = 1'b1;
        drain();

        // Backpressure: stalled consumer must cap acceptance at the FIFO depth.
        bif.out_ready = 1'b0;
        accepted = 0;
        recv0 = n_recv;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            bif.in_valid = 1'b1;
            bif.u = coeff_t'($urandom_range(QI - 1, 0));
            bif.v = coeff_t'($urandom_range(QI - 1, 0));
            bif.w = coeff_t'($urandom_range(QI - 1, 0));
            bif.mode = 1'b0;
            if (bif.in_ready) begin
                e = model(int'(bif.u), int'(bif.v), int'(bif.w), 1'b0);
                exp_q.push_back(e);
                accepted++;
            end
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        check("bp_accepted", accepted, DEPTH);
        check("bp_in_ready", int'(bif.in_ready), 0);
        check("bp_out_valid", int'(bif.out_valid), 1);
        check("bp_head_hi", int'(bif.out_hi), exp_q[0].hi);
        check("bp_head_lo", int'(bif.out_lo), exp_q[0].lo);
        bif.out_ready = 1'b1;
        drain();
        check("bp_recv", n_recv - recv0, DEPTH);

        // Reset with three items in flight discards them.
        send_rand(1'b0);
        send_rand(1'b0);
        send_rand(1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", int'(bif.out_valid), 0);
        check("mid_rst_in_ready", int'(bif.in_ready), 1);
        recv0 = n_recv;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_stale", n_recv - recv0, 0);

        // Normal operation after reset.
        send(100, 6651, 4592, 1'b0, 1836, 6045);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ntt_butterfly.md
# ntt_butterfly

Pipelined NTT butterfly for the 13-bit Kyber coefficient datapath (q = 7681). It sits directly downstream of `mult_mod` and wraps it. It takes a coefficient pair (u, v) and a twiddle w, computes u ± w·v mod q, and buffers the results behind a valid/ready handshake so the NTT controller can stall the output without the free-running multiplier pipeline losing data.

## Interface

Parameters:
- `MULT_LAT`, default 2: latency of the instantiated `mult_mod`, in cycles from a/b to mod_prod.
- `FIFO_DEPTH`, default `MULT_LAT`+2: output skid FIFO depth; must be ≥ `MULT_LAT`+2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pair and twiddle are valid.
- `in_ready`  out  1  block accepts an input this cycle.
- `mode`  in  1  0 = Cooley-Tukey (forward), 1 = Gentleman-Sande (inverse). Ignored unless `NTT_BUTTERFLY_GS_EN`.
- `u`, `v`, `w`  in  `WIDTH` each  operands, each < q.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_hi`, `out_lo`  out  `WIDTH` each  results, each < q.

## Operation

- Transfer in when `in_valid && in_ready`. Transfer out when `out_valid && out_ready`.
- CT mode:
  - `out_hi` = (u + w·v) mod q.
  - `out_lo` = (u − w·v) mod q.
- GS mode (macro enabled):
  - `out_hi` = (u + v) mod q.
  - `out_lo` = ((u − v) mod q)·w mod q.
- Modular add/sub:
  - Add: 14-bit sum; subtract q if sum ≥ q.
  - Sub: if u < x, result is u − x + q, otherwise u − x.
  - Results are always in [0, q−1].
- `mult_mod` has no enable and runs every cycle. Issue tracking:
  - A `MULT_LAT`-deep valid shift register tracks which pipeline slots hold issued items.
  - A matching delay line carries u (CT) or the add/sub partials (GS) alongside.
- Credit flow control:
  - `inflight` = number of set bits in the valid shift register plus the final-stage valid.
  - `in_ready` = (`fifo_count` + `inflight`) < `FIFO_DEPTH`.
  - Because of this rule, the pipeline never delivers into a full FIFO.
- FIFO:
  - Circular buffer, `FIFO_DEPTH` entries of {hi, lo}, read/write pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop when full or empty is legal: the count is unchanged, and pop-on-empty cannot occur.
- Reset mid-operation discards all in-flight and buffered items; no partial result is emitted.

## Timing

- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_hi` = 0, `out_lo` = 0.
  - FIFO pointers, count, and valid shift register all 0.
- Latency: input accepted in cycle N → `out_valid` high in cycle N + `MULT_LAT` + 2 if the FIFO was empty. That is `MULT_LAT` cycles of multiplier, 1 cycle of registered add/sub, and 1 cycle of FIFO write.
- Throughput: one butterfly per cycle with `out_ready` held high.
- Outputs are registered FIFO head data. `out_hi`/`out_lo` are stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered state; it is never combinational on `out_ready`.

## Configuration

- `NTT_BUTTERFLY_GS_EN` defined:
  - `mode` is honoured per item and travels down the pipeline with it.
  - GS items may be interleaved with CT items.
  - The multiplier's operand select uses `mode`.
- Not defined:
  - `mode` is unused; the block is CT-only.
  - GS delay-line logic is not synthesised.

## Structure

- Shared package `kyber_pkg`:
  - `WIDTH` = 13 and `Q` = 13'd7681.
  - `typedef logic [WIDTH-1:0] coeff_t`.
  - FIFO entry struct {coeff_t hi, lo}.
- Sub-modules:
  - `mod_add_sub`: combinational, outputs the (a+b) mod q and (a−b) mod q pair; used in both modes.
  - Existing `mult_mod`, instantiated once.

## Test plan

- u=100, w=4592, v=6651, CT → `out_hi`=1836, `out_lo`=6045 (w·v mod q = 1736), after `MULT_LAT`+2 cycles.
- u=7000, w=5623, v=7265, CT → `out_hi`=2856, `out_lo`=3463.
- Wrap boundary: u=7680, w=1, v=1 → `out_hi`=0, `out_lo`=7679. Zero case: u=v=w=0 → 0, 0.
- Backpressure:
  - Hold `out_ready`=0 and stream inputs → `in_ready` drops once `FIFO_DEPTH` items are accepted or in flight.
  - Release `out_ready` → all items emerge in order with no loss or duplication.
- Assert `rst` mid-stream with 3 items in flight → next cycle `out_valid`=0 and `in_ready`=1; no stale results appear afterwards.
- With GS enabled: u=100, v=6651, w=4592 → `out_hi`=6751, `out_lo`=((100−6651+7681)·4592) mod 7681 = (1130·4592) mod 7681.
